psu_rail_sequencer: RTL and testbench
=====================================

// Module: psu_rail_sequencer
// PURPOSE
//  Power-rail sequencer core under the tt_um_adia_psu_seq_test top level. Drives rail
//  enables from the top level's outputs and consumes power-good inputs from its inputs.
//  Brings N rails up in ascending order, waiting for each power-good plus a settle delay.
//  Brings them down in reverse order. Any power-good loss or timeout forces all rails off
//  and latches a fault.
// PARAMETERS
//  N_RAILS     4    number of rails, 2..8; rail 0 powers up first
//  TIMER_W     8    width of the shared cycle counter
//  PG_TIMEOUT  200  max cycles from en_out[i] rise to pg_in[i] high, <2**TIMER_W
//  SETTLE_CYC  16   delay cycles after pg seen (up) or after en drop (down), >=1
// PORTS
//  clk          in   1         clock, rising edge
//  rst          in   1         synchronous, active-high reset
//  start        in   1         1-cycle request to power up; honoured only in IDLE
//  stop         in   1         1-cycle request to power down; honoured in RAMP_UP/SETTLE/ON
//  clear_fault  in   1         leaves FAULT; honoured only in FAULT
//  pg_in        in   N_RAILS   power-good per rail, already synchronised upstream
//  en_out       out  N_RAILS   rail enables, registered
//  state_out    out  3         0 IDLE,1 RAMP_UP,2 SETTLE,3 ON,4 RAMP_DOWN,5 FAULT
//  fault        out  1         high while in FAULT
//  fault_rail   out  3         index of offending rail, valid while fault=1
//  fault_code   out  1         0 = pg timeout, 1 = pg lost after being seen
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): state IDLE, en_out=0, counter=0, rail index=0,
//   fault=0, fault_rail=0, fault_code=0. Reset mid-sequence drops all enables on the same edge.
//  IDLE: start=1 -> RAMP_UP rail 0. en_out[0]=1 and counter=0 on that edge (1-cycle latency).
//  RAMP_UP rail i: counter increments each cycle.
//   pg_in[i]=1 -> SETTLE with counter cleared.
//   Else if counter reaches PG_TIMEOUT-1 -> FAULT, code 0, fault_rail=i.
//  SETTLE rail i: counter increments. At SETTLE_CYC-1:
//   if i<N_RAILS-1 -> RAMP_UP rail i+1, en_out[i+1]=1 on that edge;
//   else -> ON.
//  ON: holds; all en_out=1.
//  Power-good monitoring in RAMP_UP/SETTLE/ON:
//   any rail j whose pg was already seen (j<i, or j=i in SETTLE, all j in ON)
//   reading pg_in[j]=0 -> FAULT, code 1, fault_rail=lowest such j.
//   Monitor fault beats timeout and stop in the same cycle.
//  stop in RAMP_UP/SETTLE/ON -> RAMP_DOWN starting at the highest enabled rail.
//   On that edge its en_out drops and counter=0.
//  Simultaneous start+stop: start is ignored in all non-IDLE states; in IDLE, stop is ignored.
//  RAMP_DOWN: pg is not monitored. Counter counts to SETTLE_CYC-1, then the next lower
//   rail's en_out drops. After rail 0 drops and its settle completes -> IDLE.
//   start/stop are ignored during RAMP_DOWN.
//  FAULT: en_out=0 on the entry edge (all rails at once, no ordering). fault=1.
//   fault_rail/fault_code are captured on entry and held.
//   clear_fault=1 -> IDLE, fault bits cleared. start is ignored until then.
//  Counter never wraps: it saturates at 2**TIMER_W-1.
//   Undefined state encodings -> FAULT, code 1, fault_rail=0.
// TESTING
//  N=4,PG_TIMEOUT=200,SETTLE=16, pg follows en after 5 cyc, start -> en 0001,0011,0111,1111
//   at 0,21,42,63 cyc after start edge; state ON at cyc 84.
//  Rail 2 pg never rises -> 200 cyc after en_out[2] rise: fault=1, fault_rail=2, code 0,
//   en_out=0000 same edge.
//  In ON, pulse pg_in[1]=0 for 1 cycle -> next edge FAULT, fault_rail=1, code 1;
//   clear_fault -> IDLE, fault=0.
//  stop in ON -> en 0111,0011,0001,0000 at 0,16,32,48 cyc; IDLE at cyc 64;
//   start during ramp-down is ignored.
//  start+stop same cycle in IDLE -> RAMP_UP; stop while RAMP_UP rail 1 -> en 0001 next
//   edge, then 0000 16 cyc later.
//  rst asserted in SETTLE rail 2 -> next edge en_out=0, state IDLE, fault=0;
//   start in FAULT has no effect.

Source files
------------

// File: rtl/psu_rail_sequencer.sv
// Power-rail sequencer: ordered ramp-up and reverse ramp-down of N rails,
// with power-good monitoring, ramp timeout and a latched fault.
module psu_rail_sequencer #(
    parameter int N_RAILS    = 4,
    parameter int TIMER_W    = 8,
    parameter int PG_TIMEOUT = 200,
    parameter int SETTLE_CYC = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               clear_fault,
    input  logic [N_RAILS-1:0] pg_in,
    output logic [N_RAILS-1:0] en_out,
    output logic [2:0]         state_out,
    output logic               fault,
    output logic [2:0]         fault_rail,
    output logic               fault_code
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        SETTLE    = 3'd2,
        ON        = 3'd3,
        RAMP_DOWN = 3'd4,
        FAULT     = 3'd5
    } state_t;

    localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(PG_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] ST_LAST = TIMER_W'(SETTLE_CYC - 1);
    localparam logic [TIMER_W-1:0] CNT_MAX = '1;
    localparam logic [2:0]         LAST_RAIL = 3'(N_RAILS - 1);

    state_t             state;
    logic [TIMER_W-1:0] cnt;
    logic [2:0]         idx;

    logic [N_RAILS-1:0] seen;
    logic [N_RAILS-1:0] lost;
    logic [2:0]         lost_idx;
    logic               cur_pg;
    logic [TIMER_W-1:0] cnt_inc;

    // Enable mask covering rails 0..n-1.
    function automatic logic [N_RAILS-1:0] below(input logic [3:0] n);
        logic [N_RAILS-1:0] m;
        for (int j = 0; j < N_RAILS; j++) m[j] = (4'(j) < n);
        return m;
    endfunction

    // Rails whose power-good has already been confirmed must stay good.
    always_comb begin
        seen     = '0;
        cur_pg   = 1'b0;
        lost_idx = '0;
        for (int j = 0; j < N_RAILS; j++) begin
            case (state)
                RAMP_UP: seen[j] = (3'(j) < idx);
                SETTLE:  seen[j] = (3'(j) <= idx);
                ON:      seen[j] = 1'b1;
                default: seen[j] = 1'b0;
            endcase
            if (3'(j) == idx) cur_pg = pg_in[j];
        end
        lost = seen & ~pg_in;
        for (int j = N_RAILS - 1; j >= 0; j--) begin
            if (lost[j]) lost_idx = 3'(j);
        end
        cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            en_out     <= '0;
            cnt        <= '0;
            idx        <= '0;
            fault      <= 1'b0;
            fault_rail <= '0;
            fault_code <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RAMP_UP;
                        idx    <= '0;
                        cnt    <= '0;
                        en_out <= below(4'd1);
                    end
                end
                RAMP_UP, SETTLE, ON: begin
                    if (|lost) begin
                        state      <= FAULT;
                        en_out     <= '0;
                        fault      <= 1'b1;
                        fault_rail <= lost_idx;
                        fault_code <= 1'b1;
                    end else if (state == RAMP_UP && !cur_pg && cnt == TO_LAST) begin
                        state      <= FAULT;
                        en_out     <= '0;
                        fault      <= 1'b1;
                        fault_rail <= idx;
                        fault_code <= 1'b0;
                    end else if (stop) begin
                        state  <= RAMP_DOWN;
                        cnt    <= '0;
                        en_out <= below({1'b0, idx});
                    end else if (state == RAMP_UP) begin
                        if (cur_pg) begin
                            state <= SETTLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else if (state == SETTLE) begin
                        if (cnt == ST_LAST) begin
                            cnt <= '0;
                            if (idx == LAST_RAIL) begin
                                state <= ON;
                            end else begin
                                state  <= RAMP_UP;
                                idx    <= idx + 3'd1;
                                en_out <= below({1'b0, idx} + 4'd2);
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (cnt == ST_LAST) begin
                        cnt <= '0;
                        if (idx == 3'd0) begin
                            state <= IDLE;
                        end else begin
                            idx    <= idx - 3'd1;
                            en_out <= below({1'b0, idx} - 4'd1);
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                FAULT: begin
                    if (clear_fault) begin
                        state      <= IDLE;
                        fault      <= 1'b0;
                        fault_rail <= '0;
                        fault_code <= 1'b0;
                    end
                end
                default: begin
                    state      <= FAULT;
                    en_out     <= '0;
                    fault      <= 1'b1;
                    fault_rail <= '0;
                    fault_code <= 1'b1;
                end
            endcase
        end
    end

    assign state_out = 3'(state);

endmodule

// File: tb/tb_psu_rail_sequencer.sv
// Bench for psu_rail_sequencer: timestamp-based reference model feeding a
// scoreboard queue, directed scenarios followed by random stimulus.
module tb_psu_rail_sequencer;

    localparam int N  = 4;
    localparam int TO = 200;
    localparam int ST = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stop;
    logic         clear_fault;
    logic [N-1:0] pg_in;
    logic [N-1:0] en_out;
    logic [2:0]   state_out;
    logic         fault;
    logic [2:0]   fault_rail;
    logic         fault_code;

    always #5 clk = ~clk;

    psu_rail_sequencer #(
        .N_RAILS(N), .TIMER_W(8), .PG_TIMEOUT(TO), .SETTLE_CYC(ST)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .clear_fault(clear_fault), .pg_in(pg_in), .en_out(en_out),
        .state_out(state_out), .fault(fault), .fault_rail(fault_rail),
        .fault_code(fault_code)
    );

    typedef struct packed {
        logic [N-1:0] en;
        logic [2:0]   st;
        logic         f;
        logic [2:0]   fr;
        logic         fc;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    // Model: mode 0..5, current rail, timestamp of the current step.
    int m_mode, m_cur, m_t0, m_cyc, m_fr, m_fc;
    int age[N];
    int dly[N];
    bit kill[N];

    function automatic logic [N-1:0] ones(input int k);
        return N'((1 << k) - 1);
    endfunction

    task automatic enter_fault(input int rail, input int code);
        m_mode = 5;
        m_fr = rail;
        m_fc = code;
    endtask

    task automatic model_step(input bit s, input bit sp, input bit cf,
                              input bit r, input logic [N-1:0] pg);
        int seen_n, lost, el;
        m_cyc++;
        el = m_cyc - m_t0;
        if (r) begin
            m_mode = 0; m_cur = 0; m_fr = 0; m_fc = 0; m_t0 = m_cyc;
        end else begin
            case (m_mode)
                0: if (s) begin m_mode = 1; m_cur = 0; m_t0 = m_cyc; end
                1, 2, 3: begin
                    seen_n = (m_mode == 1) ? m_cur : (m_mode == 2) ? m_cur + 1 : N;
                    lost = -1;
                    for (int j = seen_n - 1; j >= 0; j--) if (!pg[j]) lost = j;
                    if (lost >= 0) enter_fault(lost, 1);
                    else if (m_mode == 1 && !pg[m_cur] && el == TO) enter_fault(m_cur, 0);
                    else if (sp) begin m_mode = 4; m_t0 = m_cyc; end
                    else if (m_mode == 1 && pg[m_cur]) begin m_mode = 2; m_t0 = m_cyc; end
                    else if (m_mode == 2 && el == ST) begin
                        m_t0 = m_cyc;
                        if (m_cur == N - 1) m_mode = 3;
                        else begin m_mode = 1; m_cur++; end
                    end
                end
                4: if (el == ST) begin
                    m_t0 = m_cyc;
                    if (m_cur == 0) m_mode = 0;
                    else m_cur--;
                end
                5: if (cf) begin m_mode = 0; m_fr = 0; m_fc = 0; end
                default: ;
            endcase
        end
    endtask

    task automatic step(input bit s, input bit sp, input bit cf, input bit r,
                        input logic [N-1:0] gl);
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            age[i] = (en_out[i] === 1'b1) ? age[i] + 1 : 0;
            pg_in[i] = (age[i] >= dly[i]) && !kill[i] && !gl[i];
        end
        start = s; stop = sp; clear_fault = cf; rst = r;
        model_step(s, sp, cf, r, pg_in);
        case (m_mode)
            1, 2:    e.en = ones(m_cur + 1);
            3:       e.en = ones(N);
            4:       e.en = ones(m_cur);
            default: e.en = '0;
        endcase
        e.st = 3'(m_mode);
        e.f  = (m_mode == 5);
        e.fr = 3'(m_fr);
        e.fc = m_fc[0];
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, '0);
    endtask

    task automatic look();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if ({en_out, state_out, fault, fault_rail, fault_code} !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t: got en=%b st=%0d f=%b fr=%0d fc=%b, expected en=%b st=%0d f=%b fr=%0d fc=%b",
                         $time, en_out, state_out, fault, fault_rail, fault_code,
                         e.en, e.st, e.f, e.fr, e.fc);
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            dly[i] = 5; kill[i] = 0; age[i] = 0;
        end
        m_mode = 0; m_cur = 0; m_t0 = 0; m_cyc = 0; m_fr = 0; m_fc = 0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; clear_fault = 1'b0; pg_in = '0;

        step(0, 0, 0, 1, '0);
        step(0, 0, 0, 1, '0);
        look();
        chk("reset_state", state_out, 0);
        chk("reset_en", en_out, 0);
        chk("reset_fault", fault, 0);

        // Power-up: ON exactly 84 cycles after the start edge.
        step(1, 0, 0, 0, '0);
        idle(83);
        look();
        chk("pre_on_state", state_out, 2);
        chk("pre_on_en", en_out, 15);
        idle(1);
        look();
        chk("on_state", state_out, 3);

        // One-cycle pg loss on rail 1 while ON.
        idle(5);
        step(0, 0, 0, 0, 4'b0010);
        look();
        chk("pglost_fault", fault, 1);
        chk("pglost_rail", fault_rail, 1);
        chk("pglost_code", fault_code, 1);
        chk("pglost_en", en_out, 0);
        step(1, 0, 0, 0, '0);
        step(0, 0, 1, 0, '0);
        look();
        chk("clear_state", state_out, 0);
        chk("clear_fault", fault, 0);

        // Ramp-down from ON with ignored start pulses.
        step(1, 0, 0, 0, '0);
        idle(90);
        step(0, 1, 0, 0, '0);
        look();
        chk("down_first_en", en_out, 7);
        for (int k = 1; k <= 63; k++) step(k == 10 || k == 40, 0, 0, 0, '0);
        look();
        chk("down_last_state", state_out, 4);
        chk("down_last_en", en_out, 0);
        idle(1);
        look();
        chk("down_idle", state_out, 0);

        // start+stop in IDLE, then stop while ramping rail 1.
        step(1, 1, 0, 0, '0);
        look();
        chk("startstop_state", state_out, 1);
        idle(21);
        step(0, 1, 0, 0, '0);
        look();
        chk("stop_r1_en", en_out, 1);
        idle(16);
        look();
        chk("stop_r1_en_off", en_out, 0);
        idle(20);

        // Rail 2 never reports good: timeout 200 cycles after its enable.
        kill[2] = 1;
        step(1, 0, 0, 0, '0);
        idle(241);
        look();
        chk("pre_to_state", state_out, 1);
        idle(1);
        look();
        chk("to_state", state_out, 5);
        chk("to_rail", fault_rail, 2);
        chk("to_code", fault_code, 0);
        chk("to_en", en_out, 0);
        step(1, 0, 0, 0, '0);
        look();
        chk("start_in_fault", state_out, 5);
        kill[2] = 0;
        step(0, 0, 1, 0, '0);

        // Reset while settling rail 2.
        step(1, 0, 0, 0, '0);
        idle(50);
        look();
        chk("settle_r2_state", state_out, 2);
        step(0, 0, 0, 1, '0);
        look();
        chk("rst_mid_state", state_out, 0);
        chk("rst_mid_en", en_out, 0);
        chk("rst_mid_fault", fault, 0);

        // Random stimulus against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] gl;
            if (c % 400 == 0) begin
                for (int i = 0; i < N; i++) begin
                    dly[i] = $urandom_range(1, 12);
                    kill[i] = ($urandom_range(0, 7) == 0);
                end
            end
            for (int i = 0; i < N; i++) gl[i] = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 499) == 0, gl);
        end

        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
